axi_mem_bridge: RTL and testbench
=================================

AXI_MEM_BRIDGE -- requirements
Module: axi_mem_bridge

Interface
REQ-001 Parameter AXI_ADDR_WIDTH, default 64: address width on AXI and memory side.
REQ-002 Parameter AXI_DATA_WIDTH, default 64: data width; AXI_STRB_WIDTH = AXI_DATA_WIDTH/8 is derived and SHALL NOT be overridden.
REQ-003 Parameter AXI_ID_WIDTH, default 4: AXI ID width.
REQ-004 clk_i  in  1  sole clock; all logic SHALL be rising-edge clocked.
REQ-005 rst_ni  in  1  reset, asynchronous, active-low.
REQ-006 slv_aw_{addr,len,size,burst,id,atop}_i  in  AXI_ADDR_WIDTH/8/3/2/AXI_ID_WIDTH/6; slv_aw_valid_i in 1; slv_aw_ready_o out 1: AW channel.
REQ-007 slv_w_{data,strb,last,valid}_i  in  AXI_DATA_WIDTH/AXI_STRB_WIDTH/1/1; slv_w_ready_o out 1: W channel.
REQ-008 slv_b_{resp,id,valid}_o  out  2/AXI_ID_WIDTH/1; slv_b_ready_i in 1: B channel.
REQ-009 slv_ar_{addr,len,size,burst,id}_i  in  AXI_ADDR_WIDTH/8/3/2/AXI_ID_WIDTH; slv_ar_valid_i in 1; slv_ar_ready_o out 1: AR channel.
REQ-010 slv_r_{data,resp,last,id,valid}_o  out  AXI_DATA_WIDTH/2/1/AXI_ID_WIDTH/1; slv_r_ready_i in 1: R channel.
REQ-011 mem_{req,we}_o out 1/1; mem_addr_o out AXI_ADDR_WIDTH; mem_be_o out AXI_STRB_WIDTH; mem_wdata_o out AXI_DATA_WIDTH; mem_gnt_i in 1; mem_rvalid_i in 1; mem_rdata_i in AXI_DATA_WIDTH: single-port memory request/grant port.

Function
REQ-012 Block SHALL sit downstream of the atomics adapter, converting its master-side AXI traffic into memory-port accesses, one AXI transaction at a time.
REQ-013 FSM states SHALL be IDLE, WRITE, WRESP, RREQ, RWAIT, RDATA.
REQ-014 IDLE: aw_ready/ar_ready SHALL be asserted; if both valid in one cycle, a round-robin bit SHALL select, write first after reset, toggling after each grant.
REQ-015 AW handshake SHALL latch addr/len/size/burst/id and go to WRITE; AR handshake SHALL latch the same fields and go to RREQ.
REQ-016 WRITE: mem_req_o=slv_w_valid_i, mem_we_o=1, mem_be_o=strb, mem_wdata_o=data; slv_w_ready_o=mem_gnt_i (combinational, same cycle).
REQ-017 Each W handshake SHALL advance address; handshake with w_last=1 SHALL go to WRESP irrespective of beat count.
REQ-018 WRESP: b_valid=1, b_resp=OKAY(00), b_id=latched id; B handshake SHALL return to IDLE.
REQ-019 RREQ: mem_req_o=1, mem_we_o=0; on mem_gnt_i go to RWAIT; mem_rvalid_i arrives exactly one cycle after grant.
REQ-020 RWAIT: on mem_rvalid_i capture rdata into register, go to RDATA; r_valid SHALL be registered (first r_valid two cycles after grant).
REQ-021 RDATA: r_valid=1, r_resp=OKAY, r_id=latched id, r_last=1 when beat counter equals latched len; on R handshake, last beat -> IDLE, otherwise advance address, -> RREQ.
REQ-022 Address update: FIXED(00) keeps address; INCR(01) and WRAP(10) add (1<<size) modulo 2^AXI_ADDR_WIDTH (wrap-around at top of space permitted); beat counter 8 bits, len 255 = 256 beats.
REQ-023 Unused outputs SHALL be driven zero when their valid/req is low; at most one memory request SHALL be outstanding.

Reset
REQ-024 rst_ni low SHALL force IDLE immediately, including mid-burst; round-robin bit to write; counters, latched fields and rdata register to 0; all valid/req outputs 0; slv_aw_ready_o and slv_ar_ready_o 1 only after reset deasserts.

Configuration
REQ-025 Macro AXI_MEM_BRIDGE_ATOP_ERR_EN defined: AW with atop!=0 SHALL perform no memory write; W beats are accepted (w_ready=1) and dropped until w_last; B returns SLVERR(10).
REQ-026 Macro undefined: atop SHALL be ignored and the write performed as a normal write with OKAY.

Verification
REQ-027 AW addr=0x100,len=0,size=3,id=5 + W data=0xA5,strb=0xFF,last=1, gnt=1 -> one mem write addr 0x100, be 0xFF; B id=5 resp=00.
REQ-028 AR addr=0x200,len=3,size=3,INCR, rdata=beat index -> mem reads 0x200/0x208/0x210/0x218; R data 0..3, r_last only on beat 3.
REQ-029 AW and AR valid in the same cycle twice in succession -> write served first, read second.
REQ-030 AR FIXED len=1 addr 0x40, r_ready held low 5 cycles -> r_valid/data stable, no new mem_req until handshake, both reads at 0x40.
REQ-031 With macro: AW atop=0x20, 2 W beats -> no mem_req, B resp=10; without macro -> 2 mem writes, resp=00.
REQ-032 rst_ni pulsed low during RDATA of a len=7 read -> all valids 0 immediately; after release, new AR handled from IDLE correctly.

Source files
------------

// File: rtl/axi_mem_bridge.sv
// AXI slave to single-port memory bridge, serving one AXI transaction at a time.
// Optional build macro AXI_MEM_BRIDGE_ATOP_ERR_EN: atomic writes are dropped and answered with SLVERR.
module axi_mem_bridge #(
    parameter int  AXI_ADDR_WIDTH = 64,
    parameter int  AXI_DATA_WIDTH = 64,
    parameter int  AXI_ID_WIDTH   = 4,
    localparam int AXI_STRB_WIDTH = AXI_DATA_WIDTH / 8
) (
    input  logic                      clk_i,
    input  logic                      rst_ni,
    input  logic [AXI_ADDR_WIDTH-1:0] slv_aw_addr_i,
    input  logic [7:0]                slv_aw_len_i,
    input  logic [2:0]                slv_aw_size_i,
    input  logic [1:0]                slv_aw_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   slv_aw_id_i,
    input  logic [5:0]                slv_aw_atop_i,
    input  logic                      slv_aw_valid_i,
    output logic                      slv_aw_ready_o,
    input  logic [AXI_DATA_WIDTH-1:0] slv_w_data_i,
    input  logic [AXI_STRB_WIDTH-1:0] slv_w_strb_i,
    input  logic                      slv_w_last_i,
    input  logic                      slv_w_valid_i,
    output logic                      slv_w_ready_o,
    output logic [1:0]                slv_b_resp_o,
    output logic [AXI_ID_WIDTH-1:0]   slv_b_id_o,
    output logic                      slv_b_valid_o,
    input  logic                      slv_b_ready_i,
    input  logic [AXI_ADDR_WIDTH-1:0] slv_ar_addr_i,
    input  logic [7:0]                slv_ar_len_i,
    input  logic [2:0]                slv_ar_size_i,
    input  logic [1:0]                slv_ar_burst_i,
    input  logic [AXI_ID_WIDTH-1:0]   slv_ar_id_i,
    input  logic                      slv_ar_valid_i,
    output logic                      slv_ar_ready_o,
    output logic [AXI_DATA_WIDTH-1:0] slv_r_data_o,
    output logic [1:0]                slv_r_resp_o,
    output logic                      slv_r_last_o,
    output logic [AXI_ID_WIDTH-1:0]   slv_r_id_o,
    output logic                      slv_r_valid_o,
    input  logic                      slv_r_ready_i,
    output logic                      mem_req_o,
    output logic                      mem_we_o,
    output logic [AXI_ADDR_WIDTH-1:0] mem_addr_o,
    output logic [AXI_STRB_WIDTH-1:0] mem_be_o,
    output logic [AXI_DATA_WIDTH-1:0] mem_wdata_o,
    input  logic                      mem_gnt_i,
    input  logic                      mem_rvalid_i,
    input  logic [AXI_DATA_WIDTH-1:0] mem_rdata_i
);

`ifdef AXI_MEM_BRIDGE_ATOP_ERR_EN
    localparam bit ATOP_ERR_EN = 1'b1;
`else
    localparam bit ATOP_ERR_EN = 1'b0;
`endif

    typedef enum logic [2:0] {IDLE, WRITE, WRESP, RREQ, RWAIT, RDATA} state_e;

    state_e                    state;
    logic                      rr_wr;
    logic                      rdy_en;
    logic                      atop_err_q;
    logic [AXI_ADDR_WIDTH-1:0] addr_q;
    logic [7:0]                len_q;
    logic [7:0]                cnt_q;
    logic [2:0]                size_q;
    logic [1:0]                burst_q;
    logic [AXI_ID_WIDTH-1:0]   id_q;
    logic [AXI_DATA_WIDTH-1:0] rdata_p0;

    logic aw_hs, ar_hs, w_hs, wr_beat, r_last;

    function automatic logic [AXI_ADDR_WIDTH-1:0] next_addr(
        input logic [AXI_ADDR_WIDTH-1:0] addr,
        input logic [2:0]                size,
        input logic [1:0]                burst
    );
        if (burst == 2'b00)
            return addr;
        return addr + (AXI_ADDR_WIDTH'(1) << size);
    endfunction

    // rdy_en keeps both address channels closed until the first edge after reset release.
    assign slv_aw_ready_o = (state == IDLE) && rdy_en && (!slv_ar_valid_i || rr_wr);
    assign slv_ar_ready_o = (state == IDLE) && rdy_en && (!slv_aw_valid_i || !rr_wr);
    assign aw_hs          = slv_aw_valid_i && slv_aw_ready_o;
    assign ar_hs          = slv_ar_valid_i && slv_ar_ready_o;

    assign wr_beat        = (state == WRITE) && !atop_err_q && slv_w_valid_i;
    assign slv_w_ready_o  = (state == WRITE) && (atop_err_q || mem_gnt_i);
    assign w_hs           = slv_w_valid_i && slv_w_ready_o;

    assign mem_req_o      = wr_beat || (state == RREQ);
    assign mem_we_o       = wr_beat;
    assign mem_addr_o     = mem_req_o ? addr_q : '0;
    assign mem_be_o       = wr_beat ? slv_w_strb_i : '0;
    assign mem_wdata_o    = wr_beat ? slv_w_data_i : '0;

    assign slv_b_valid_o  = (state == WRESP);
    assign slv_b_resp_o   = (slv_b_valid_o && atop_err_q) ? 2'b10 : 2'b00;
    assign slv_b_id_o     = slv_b_valid_o ? id_q : '0;

    assign r_last         = (cnt_q == len_q);
    assign slv_r_valid_o  = (state == RDATA);
    assign slv_r_data_o   = slv_r_valid_o ? rdata_p0 : '0;
    assign slv_r_resp_o   = 2'b00;
    assign slv_r_last_o   = slv_r_valid_o && r_last;
    assign slv_r_id_o     = slv_r_valid_o ? id_q : '0;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= IDLE;
            rr_wr      <= 1'b1;
            rdy_en     <= 1'b0;
            atop_err_q <= 1'b0;
            addr_q     <= '0;
            len_q      <= '0;
            cnt_q      <= '0;
            size_q     <= '0;
            burst_q    <= '0;
            id_q       <= '0;
            rdata_p0   <= '0;
        end else begin
            rdy_en <= 1'b1;
            case (state)
                IDLE: begin
                    if (aw_hs || ar_hs) begin
                        addr_q     <= aw_hs ? slv_aw_addr_i  : slv_ar_addr_i;
                        len_q      <= aw_hs ? slv_aw_len_i   : slv_ar_len_i;
                        size_q     <= aw_hs ? slv_aw_size_i  : slv_ar_size_i;
                        burst_q    <= aw_hs ? slv_aw_burst_i : slv_ar_burst_i;
                        id_q       <= aw_hs ? slv_aw_id_i    : slv_ar_id_i;
                        atop_err_q <= aw_hs && ATOP_ERR_EN && (slv_aw_atop_i != 6'd0);
                        cnt_q      <= '0;
                        rr_wr      <= ~rr_wr;
                        state      <= aw_hs ? WRITE : RREQ;
                    end
                end
                WRITE: begin
                    if (w_hs) begin
                        addr_q <= next_addr(addr_q, size_q, burst_q);
                        cnt_q  <= cnt_q + 8'd1;
                        if (slv_w_last_i)
                            state <= WRESP;
                    end
                end
                WRESP: begin
                    if (slv_b_ready_i)
                        state <= IDLE;
                end
                RREQ: begin
                    if (mem_gnt_i)
                        state <= RWAIT;
                end
                RWAIT: begin
                    if (mem_rvalid_i) begin
                        rdata_p0 <= mem_rdata_i;
                        state    <= RDATA;
                    end
                end
                RDATA: begin
                    if (slv_r_ready_i) begin
                        if (r_last) begin
                            state <= IDLE;
                        end else begin
                            addr_q <= next_addr(addr_q, size_q, burst_q);
                            cnt_q  <= cnt_q + 8'd1;
                            state  <= RREQ;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_bridge.sv
// Randomized bench for axi_mem_bridge with a behavioural memory and transaction-level reference model.
module tb_axi_mem_bridge;
    localparam int AW = 64, DW = 64, IW = 4, SW = DW / 8;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic [AW-1:0] aw_addr, ar_addr, mem_addr;
    logic [7:0]    aw_len, ar_len;
    logic [2:0]    aw_size, ar_size;
    logic [1:0]    aw_burst, ar_burst, b_resp, r_resp;
    logic [IW-1:0] aw_id, ar_id, b_id, r_id;
    logic [5:0]    aw_atop;
    logic          aw_valid, aw_ready, ar_valid, ar_ready;
    logic [DW-1:0] w_data, r_data, mem_wdata;
    logic [SW-1:0] w_strb, mem_be;
    logic          w_last, w_valid, w_ready, b_valid, b_ready;
    logic          r_last, r_valid, r_ready, mem_req, mem_we;
    logic          mem_gnt = 1'b0;
    logic          mem_rvalid = 1'b0;
    logic [DW-1:0] mem_rdata = '0;

    axi_mem_bridge #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW), .AXI_ID_WIDTH(IW)) dut (
        .clk_i(clk), .rst_ni(rst_n),
        .slv_aw_addr_i(aw_addr), .slv_aw_len_i(aw_len), .slv_aw_size_i(aw_size),
        .slv_aw_burst_i(aw_burst), .slv_aw_id_i(aw_id), .slv_aw_atop_i(aw_atop),
        .slv_aw_valid_i(aw_valid), .slv_aw_ready_o(aw_ready),
        .slv_w_data_i(w_data), .slv_w_strb_i(w_strb), .slv_w_last_i(w_last),
        .slv_w_valid_i(w_valid), .slv_w_ready_o(w_ready),
        .slv_b_resp_o(b_resp), .slv_b_id_o(b_id), .slv_b_valid_o(b_valid), .slv_b_ready_i(b_ready),
        .slv_ar_addr_i(ar_addr), .slv_ar_len_i(ar_len), .slv_ar_size_i(ar_size),
        .slv_ar_burst_i(ar_burst), .slv_ar_id_i(ar_id),
        .slv_ar_valid_i(ar_valid), .slv_ar_ready_o(ar_ready),
        .slv_r_data_o(r_data), .slv_r_resp_o(r_resp), .slv_r_last_o(r_last),
        .slv_r_id_o(r_id), .slv_r_valid_o(r_valid), .slv_r_ready_i(r_ready),
        .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr), .mem_be_o(mem_be),
        .mem_wdata_o(mem_wdata), .mem_gnt_i(mem_gnt), .mem_rvalid_i(mem_rvalid), .mem_rdata_i(mem_rdata)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Memory contents: writes seen on the port, directed preloads, otherwise an address pattern.
    logic [63:0] wr_mem  [logic [63:0]];
    logic [63:0] pre_mem [logic [63:0]];
    logic [63:0] wl_addr[$], wl_data[$], rl_addr[$];
    logic [7:0]  wl_be[$];
    int          rd_grant_cnt = 0;
    int          rd_served_cnt = 0;
    logic [63:0] pend_addr = '0;

    function automatic logic [63:0] mem_rd(input logic [63:0] a);
        if (wr_mem.exists(a)) return wr_mem[a];
        if (pre_mem.exists(a)) return pre_mem[a];
        return {~a[31:0], a[31:0]} ^ 64'h5A5A_0F0F_3C3C_9696;
    endfunction

    function automatic logic [63:0] merge(input logic [63:0] old, input logic [63:0] d, input logic [7:0] be);
        logic [63:0] r;
        r = old;
        for (int k = 0; k < 8; k++)
            if (be[k]) r[k*8 +: 8] = d[k*8 +: 8];
        return r;
    endfunction

    function automatic logic [63:0] ex_addr(input logic [63:0] a, input logic [2:0] s, input logic [1:0] b, input int i);
        if (b == 2'b00) return a;
        return a + 64'(i) * (64'd1 << s);
    endfunction

    always @(negedge clk) begin
        #2;
        if (rst_n) begin
            if (mem_rvalid) chk("one_outstanding", 64'(mem_req), 64'd0);
            if (!mem_req) begin
                chk("mem_idle_zero", mem_addr | mem_wdata | 64'(mem_be) | 64'(mem_we), 64'd0);
            end else if (mem_gnt) begin
                if (mem_we) begin
                    wl_addr.push_back(mem_addr);
                    wl_data.push_back(mem_wdata);
                    wl_be.push_back(mem_be);
                    wr_mem[mem_addr] = merge(mem_rd(mem_addr), mem_wdata, mem_be);
                end else begin
                    rl_addr.push_back(mem_addr);
                    pend_addr = mem_addr;
                    rd_grant_cnt++;
                end
            end
        end
    end

    always @(posedge clk) begin
        #1;
        if (rd_grant_cnt != rd_served_cnt) begin
            mem_rvalid = 1'b1;
            mem_rdata = mem_rd(pend_addr);
            rd_served_cnt = rd_grant_cnt;
        end else begin
            mem_rvalid = 1'b0;
            mem_rdata = {$urandom, $urandom};
        end
        mem_gnt = ($urandom_range(0, 3) != 0);
    end

    bit prio_wr = 1'b1;

    task automatic aw_drive(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id, input logic [5:0] at);
        aw_addr = a; aw_len = l; aw_size = s; aw_burst = b; aw_id = id; aw_atop = at; aw_valid = 1'b1;
    endtask

    task automatic ar_drive(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                            input logic [1:0] b, input logic [3:0] id);
        ar_addr = a; ar_len = l; ar_size = s; ar_burst = b; ar_id = id; ar_valid = 1'b1;
    endtask

    task automatic wait_grant(input bit is_aw);
        int t;
        t = 0;
        #1;
        while (!(is_aw ? aw_ready : ar_ready) && t < 200) begin
            @(negedge clk); #1; t++;
        end
        if (t >= 200) begin
            if (is_aw) chk("aw_timeout", 64'd1, 64'd0);
            else       chk("ar_timeout", 64'd1, 64'd0);
        end else begin
            prio_wr = !prio_wr;
        end
        @(negedge clk);
        if (is_aw) aw_valid = 1'b0;
        else       ar_valid = 1'b0;
    endtask

    task automatic write_body(input logic [63:0] a, input logic [2:0] s, input logic [1:0] b,
                              input logic [3:0] id, input bit err, input int nb, input bit dir);
        logic [63:0] ed[$];
        logic [7:0]  es[$];
        int base, t, n_exp;
        bit hs;
        base = wl_addr.size();
        for (int i = 0; i < nb; i++) begin
            w_valid = 1'b0;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            w_data  = dir ? 64'hA5 : {$urandom, $urandom};
            w_strb  = dir ? 8'hFF : 8'($urandom);
            w_last  = (i == nb - 1);
            w_valid = 1'b1;
            ed.push_back(w_data);
            es.push_back(w_strb);
            t = 0;
            #1;
            while (!w_ready && t < 200) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 200) begin
                chk("w_timeout", 64'd1, 64'd0);
                w_valid = 1'b0;
                return;
            end
            @(negedge clk);
        end
        w_valid = 1'b0;
        w_last  = 1'b0;
        t  = 0;
        hs = 1'b0;
        while (!hs && t < 200) begin
            b_ready = 1'($urandom_range(0, 1));
            #1;
            hs = b_valid && b_ready;
            if (!hs) begin
                @(negedge clk); t++;
            end
        end
        if (!hs) begin
            chk("b_timeout", 64'd1, 64'd0);
        end else begin
            chk("b_id", 64'(b_id), 64'(id));
            chk("b_resp", 64'(b_resp), err ? 64'd2 : 64'd0);
            @(negedge clk);
        end
        b_ready = 1'b0;
        n_exp = err ? 0 : nb;
        chk("wr_count", 64'(wl_addr.size() - base), 64'(n_exp));
        for (int i = 0; i < n_exp && base + i < wl_addr.size(); i++) begin
            chk("wr_addr", wl_addr[base + i], ex_addr(a, s, b, i));
            chk("wr_be", 64'(wl_be[base + i]), 64'(es[i]));
            chk("wr_data", wl_data[base + i], ed[i]);
        end
    endtask

    task automatic read_body(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                             input logic [1:0] b, input logic [3:0] id, input bit stall);
        int base, t;
        logic [63:0] held;
        base = rl_addr.size();
        for (int i = 0; i <= int'(l); i++) begin
            r_ready = 1'b0;
            t = 0;
            #1;
            while (!r_valid && t < 300) begin
                @(negedge clk); #1; t++;
            end
            if (t >= 300) begin
                chk("r_timeout", 64'd1, 64'd0);
                return;
            end
            if (stall) begin
                held = r_data;
                for (int k = 0; k < 5; k++) begin
                    @(negedge clk); #1;
                    chk("r_stall_valid", 64'(r_valid), 64'd1);
                    chk("r_stall_data", r_data, held);
                    chk("r_stall_no_req", 64'(mem_req), 64'd0);
                end
            end
            r_ready = 1'b1;
            chk("r_data", r_data, mem_rd(ex_addr(a, s, b, i)));
            chk("r_last", 64'(r_last), 64'(i == int'(l)));
            chk("r_id", 64'(r_id), 64'(id));
            chk("r_resp", 64'(r_resp), 64'd0);
            @(negedge clk);
            r_ready = 1'b0;
        end
        chk("rd_count", 64'(rl_addr.size() - base), 64'(int'(l) + 1));
        for (int i = 0; i <= int'(l) && base + i < rl_addr.size(); i++)
            chk("rd_addr", rl_addr[base + i], ex_addr(a, s, b, i));
    endtask

    task automatic do_write(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s, input logic [1:0] b,
                            input logic [3:0] id, input logic [5:0] at, input bit err, input int nb, input bit dir);
        aw_drive(a, l, s, b, id, at);
        wait_grant(1'b1);
        write_body(a, s, b, id, err, nb, dir);
    endtask

    task automatic do_read(input logic [63:0] a, input logic [7:0] l, input logic [2:0] s,
                           input logic [1:0] b, input logic [3:0] id, input bit stall);
        ar_drive(a, l, s, b, id);
        wait_grant(1'b0);
        read_body(a, l, s, b, id, stall);
    endtask

    task automatic pair_txn(input logic [63:0] wa, input logic [7:0] wl, input logic [63:0] ra, input logic [7:0] rl,
                            input logic [2:0] s, input logic [1:0] b);
        aw_drive(wa, wl, s, b, 4'd1, 6'd0);
        ar_drive(ra, rl, s, b, 4'd2);
        #1;
        chk("arb_aw_ready", 64'(aw_ready), 64'(prio_wr));
        chk("arb_ar_ready", 64'(ar_ready), 64'(!prio_wr));
        if (prio_wr) begin
            wait_grant(1'b1);
            write_body(wa, s, b, 4'd1, 1'b0, int'(wl) + 1, 1'b0);
            wait_grant(1'b0);
            read_body(ra, rl, s, b, 4'd2, 1'b0);
        end else begin
            wait_grant(1'b0);
            read_body(ra, rl, s, b, 4'd2, 1'b0);
            wait_grant(1'b1);
            write_body(wa, s, b, 4'd1, 1'b0, int'(wl) + 1, 1'b0);
        end
    endtask

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        bit atop_err_exp;
        logic [63:0] a;
        logic [7:0]  l;
        logic [2:0]  s;
        logic [1:0]  b;
        int t;
`ifdef AXI_MEM_BRIDGE_ATOP_ERR_EN
        atop_err_exp = 1'b1;
`else
        atop_err_exp = 1'b0;
`endif
        aw_addr = '0; aw_len = '0; aw_size = '0; aw_burst = '0; aw_id = '0; aw_atop = '0; aw_valid = 1'b0;
        ar_addr = '0; ar_len = '0; ar_size = '0; ar_burst = '0; ar_id = '0; ar_valid = 1'b0;
        w_data = '0; w_strb = '0; w_last = 1'b0; w_valid = 1'b0; b_ready = 1'b0; r_ready = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_ar_ready", 64'(ar_ready), 64'd0);
        chk("rst_b_valid", 64'(b_valid), 64'd0);
        chk("rst_r_valid", 64'(r_valid), 64'd0);
        chk("rst_mem_req", 64'(mem_req), 64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("idle_aw_ready", 64'(aw_ready), 64'd1);
        chk("idle_ar_ready", 64'(ar_ready), 64'd1);
        @(negedge clk);

        pair_txn(64'h1000, 8'd1, 64'h2000, 8'd2, 3'd3, 2'b01);
        pair_txn(64'h1100, 8'd0, 64'h2100, 8'd1, 3'd2, 2'b01);

        do_write(64'h100, 8'd0, 3'd3, 2'b01, 4'd5, 6'd0, 1'b0, 1, 1'b1);

        for (int i = 0; i < 4; i++) pre_mem[64'h200 + 64'(8 * i)] = 64'(i);
        do_read(64'h200, 8'd3, 3'd3, 2'b01, 4'd6, 1'b0);

        do_read(64'h40, 8'd1, 3'd3, 2'b00, 4'd2, 1'b1);

        do_write(64'h500, 8'd1, 3'd3, 2'b01, 4'd7, 6'h20, atop_err_exp, 2, 1'b0);

        do_write(64'h600, 8'd3, 3'd2, 2'b01, 4'd3, 6'd0, 1'b0, 2, 1'b0);

        do_write(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b01, 4'd4, 6'd0, 1'b0, 2, 1'b0);
        do_read(64'hFFFF_FFFF_FFFF_FFF8, 8'd1, 3'd3, 2'b10, 4'd4, 1'b0);

        do_read({$urandom, $urandom}, 8'd255, 3'd0, 2'b01, 4'd8, 1'b0);

        for (int n = 0; n < 30; n++) begin
            a = {$urandom, $urandom};
            l = 8'($urandom_range(0, 7));
            s = 3'($urandom_range(0, 3));
            b = 2'($urandom_range(0, 2));
            case ($urandom_range(0, 2))
                0: do_write(a, l, s, b, 4'($urandom), 6'd0, 1'b0, int'(l) + 1, 1'b0);
                1: do_read(a, l, s, b, 4'($urandom), 1'($urandom_range(0, 1)));
                default: pair_txn(a, l, {$urandom, $urandom}, 8'($urandom_range(0, 7)), s, b);
            endcase
        end

        ar_drive(64'h3000, 8'd7, 3'd3, 2'b01, 4'd9);
        wait_grant(1'b0);
        t = 0;
        #1;
        while (!r_valid && t < 200) begin
            @(negedge clk); #1; t++;
        end
        chk("rst_mid_rvalid_seen", 64'(r_valid), 64'd1);
        rst_n = 1'b0;
        #1;
        chk("rst_mid_r_valid", 64'(r_valid), 64'd0);
        chk("rst_mid_r_data", r_data, 64'd0);
        chk("rst_mid_mem_req", 64'(mem_req), 64'd0);
        chk("rst_mid_b_valid", 64'(b_valid), 64'd0);
        chk("rst_mid_aw_ready", 64'(aw_ready), 64'd0);
        chk("rst_mid_ar_ready", 64'(ar_ready), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        prio_wr = 1'b1;
        @(negedge clk);
        do_read(64'h4000, 8'd2, 3'd3, 2'b01, 4'd3, 1'b0);
        pair_txn(64'h5000, 8'd0, 64'h6000, 8'd0, 3'd3, 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
